// File: rtl/alu_share_seq.sv
// alu_share_seq: time-shares one combinational ALU between the PC incrementer
// (requester 0) and the execute stage (requester 1). Round-robin grant,
// valid/ready accept, one EXEC cycle of stable operands, then a one-cycle
// response pulse to whichever requester owns the operation.

module alu_share_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             req1_ready,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_switch,
    input  logic [WIDTH-1:0] alu_result,

    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic       can_accept;
    logic       grant0;
    logic       grant1;

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not
    // served last. Accepts are only possible outside EXEC, since RESP overlaps
    // with the next accept to reach one operation every two cycles.
    always_comb begin
        can_accept = (state == IDLE) || (state == RESP);
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = can_accept && grant0;
        req1_ready = can_accept && grant1;
        busy       = (state == EXEC);
    end

    // Sequencer: reset wins over any accept; accept loads the ALU operands,
    // EXEC captures the ALU output, RESP pulses the owner's response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_switch  <= 2'b00;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    if (req0_ready) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_switch <= req0_op;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (req1_ready) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_switch <= req1_op;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    resp_result <= alu_result;
                    resp_zero   <= (alu_result == '0);
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                    state       <= RESP;
                end
                default: begin
                    state       <= IDLE;
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_seq.sv
// tb_alu_share_seq: directed bench for alu_share_seq. The bench plays the
// combinational ALU and keeps a scoreboard of expected responses, each tagged
// with the cycle in which its response pulse must appear.

module tb_alu_share_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic [1:0]       req0_op = 2'b00;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic [1:0]       req1_op = 2'b00;
    logic             req1_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_switch;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp0_valid;
    logic             resp1_valid;
    logic             busy;

    typedef struct {
        int               due;
        bit               owner;
        logic [WIDTH-1:0] res;
    } sb_entry_t;

    sb_entry_t sb[$];
    int nAsserts = 0;
    int nFails   = 0;
    int cycleNum = 0;

    alu_share_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .req1_ready  (req1_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_switch  (alu_switch),
        .alu_result  (alu_result),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .busy        (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] aluModel(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: return a & b;
        endcase
    endfunction

    // The external ALU seen by the sequencer.
    assign alu_result = aluModel(alu_a, alu_b, alu_switch);

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare response outputs against the scoreboard entry due this cycle.
    task automatic checkResp();
        sb_entry_t e;
        if (sb.size() > 0 && sb[0].due == cycleNum) begin
            e = sb.pop_front();
            checkOutput("resp0_valid", {31'd0, resp0_valid}, {31'd0, !e.owner});
            checkOutput("resp1_valid", {31'd0, resp1_valid}, {31'd0, e.owner});
            checkOutput("resp_result", resp_result, e.res);
            checkOutput("resp_zero", {31'd0, resp_zero}, {31'd0, e.res == '0});
        end else begin
            checkOutput("resp0_idle", {31'd0, resp0_valid}, '0);
            checkOutput("resp1_idle", {31'd0, resp1_valid}, '0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cycleNum++;
        checkResp();
    endtask

    // Drive both requesters, check the grant, and log any expected accept.
    task automatic applyStimulus(input bit v0, input logic [WIDTH-1:0] a0,
                                 input logic [WIDTH-1:0] b0, input logic [1:0] op0,
                                 input bit v1, input logic [WIDTH-1:0] a1,
                                 input logic [WIDTH-1:0] b1, input logic [1:0] op1,
                                 input bit exp0, input bit exp1);
        sb_entry_t e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        #1;
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, exp0});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, exp1});
        if (exp0) begin
            e.due = cycleNum + 2; e.owner = 1'b0; e.res = aluModel(a0, b0, op0);
            sb.push_back(e);
        end else if (exp1) begin
            e.due = cycleNum + 2; e.owner = 1'b1; e.res = aluModel(a1, b1, op1);
            sb.push_back(e);
        end
    endtask

    task automatic idleInputs();
        applyStimulus(0, '0, '0, 2'b00, 0, '0, '0, 2'b00, 0, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_alu_a"}, alu_a, '0);
        checkOutput({tag, "_alu_b"}, alu_b, '0);
        checkOutput({tag, "_alu_switch"}, {30'd0, alu_switch}, '0);
        checkOutput({tag, "_resp_result"}, resp_result, '0);
        checkOutput({tag, "_resp_zero"}, {31'd0, resp_zero}, '0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, '0);
        checkOutput({tag, "_ready0"}, {31'd0, req0_ready}, '0);
        checkOutput({tag, "_ready1"}, {31'd0, req1_ready}, '0);
    endtask

    // Directed sequence mirroring the block's test plan.
    initial begin
        int k;
        logic [WIDTH-1:0] da [0:4];
        logic [WIDTH-1:0] db [0:4];
        logic [1:0]       dop [0:4];

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        checkResetOutputs("reset");
        rst = 1'b0;

        // Requester 0 alone: 5 + 3
        applyStimulus(1, 32'd5, 32'd3, 2'b00, 0, '0, '0, 2'b00, 1, 0);
        cycle();
        checkOutput("busy_exec0", {31'd0, busy}, 32'd1);
        idleInputs();
        cycle();
        checkOutput("busy_resp0", {31'd0, busy}, '0);
        cycle();

        // Requester 1 alone: 7 - 7 gives zero
        applyStimulus(0, '0, '0, 2'b00, 1, 32'd7, 32'd7, 2'b01, 0, 1);
        cycle();
        idleInputs();
        cycle();
        cycle();

        // Tie straight after reset: requester 0 first, requester 1 in RESP
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        applyStimulus(1, 32'd1, 32'd1, 2'b00, 1, 32'hFF, 32'h0F, 2'b11, 1, 0);
        cycle();
        applyStimulus(0, '0, '0, 2'b00, 1, 32'hFF, 32'h0F, 2'b11, 0, 0);
        cycle();
        applyStimulus(0, '0, '0, 2'b00, 1, 32'hFF, 32'h0F, 2'b11, 0, 1);
        cycle();
        idleInputs();
        cycle();
        cycle();

        // Continuous contention for four operations: grants alternate 0,1,0,1
        for (int i = 0; i < 5; i++) begin
            da[i] = 32'd100 + 32'(i);
            db[i] = 32'd3 * 32'(i) + 32'd1;
            dop[i] = 2'(i);
        end
        for (k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                applyStimulus(1, da[k], db[k], dop[k], 1, da[k+1], db[k+1], dop[k+1], 1, 0);
            else
                applyStimulus(1, da[k+1], db[k+1], dop[k+1], 1, da[k], db[k], dop[k], 0, 1);
            cycle();
            checkOutput("busy_rr_exec", {31'd0, busy}, 32'd1);
            if (k % 2 == 0)
                applyStimulus(1, da[k+1], db[k+1], dop[k+1], 1, da[k+1], db[k+1], dop[k+1], 0, 0);
            else
                applyStimulus(1, da[k+1], db[k+1], dop[k+1], 1, da[k+2], db[k+2], dop[k+2], 0, 0);
            cycle();
            checkOutput("busy_rr_resp", {31'd0, busy}, '0);
        end
        idleInputs();
        cycle();
        cycle();

        // Requester 0 back-to-back AND: op held, operands update per accept
        applyStimulus(1, 32'hF0F0, 32'hFF00, 2'b11, 0, '0, '0, 2'b00, 1, 0);
        cycle();
        checkOutput("and1_alu_a", alu_a, 32'hF0F0);
        checkOutput("and1_alu_b", alu_b, 32'hFF00);
        checkOutput("and1_switch", {30'd0, alu_switch}, 32'd3);
        applyStimulus(1, 32'h1234, 32'hFFFF, 2'b11, 0, '0, '0, 2'b00, 0, 0);
        checkOutput("exec_hold_alu_a", alu_a, 32'hF0F0);
        cycle();
        checkOutput("and_resp_val", resp_result, 32'hF000);
        applyStimulus(1, 32'h1234, 32'hFFFF, 2'b11, 0, '0, '0, 2'b00, 1, 0);
        cycle();
        checkOutput("and2_alu_a", alu_a, 32'h1234);
        checkOutput("and2_alu_b", alu_b, 32'hFFFF);
        checkOutput("and2_switch", {30'd0, alu_switch}, 32'd3);
        idleInputs();
        cycle();
        checkOutput("and_resp_val2", resp_result, 32'h1234);
        cycle();
        checkOutput("resp_hold", resp_result, 32'h1234);

        // Reset during EXEC of a requester-1 op aborts it
        applyStimulus(0, '0, '0, 2'b00, 1, 32'd2, 32'd3, 2'b00, 0, 1);
        cycle();
        checkOutput("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        sb.delete();
        idleInputs();
        cycle();
        checkResetOutputs("abort");
        rst = 1'b0;
        cycle();
        applyStimulus(1, 32'd9, 32'd4, 2'b01, 1, 32'd6, 32'd6, 2'b11, 1, 0);
        cycle();
        applyStimulus(0, '0, '0, 2'b00, 1, 32'd6, 32'd6, 2'b11, 0, 0);
        cycle();
        applyStimulus(0, '0, '0, 2'b00, 1, 32'd6, 32'd6, 2'b11, 0, 1);
        cycle();
        idleInputs();
        cycle();
        cycle();

        checkOutput("scoreboard_empty", 32'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
